// File: rtl/lcd_ctrl_pkg.sv
// Shared types and helpers for the LCD sprite position controller.
// Position arithmetic is done in 9 bits so the increment clamp cannot wrap.
package lcd_ctrl_pkg;

  typedef enum logic [1:0] {
    StManual,
    StSweepUp,
    StSweepDown
  } state_e;

  typedef enum logic [1:0] {
    CmdNone,
    CmdInc,
    CmdDec
  } cmd_e;

  localparam int unsigned KEY_SEL   = 0;
  localparam int unsigned KEY_LEFT  = 1;
  localparam int unsigned KEY_RIGHT = 2;
  localparam int unsigned KEY_AUTO  = 3;

  function automatic logic [7:0] pos_inc(input logic [7:0] pos, input int unsigned step,
                                         input int unsigned max_pos);
    logic [8:0] sum;
    sum = {1'b0, pos} + 9'(step);
    return (sum > 9'(max_pos)) ? 8'(max_pos) : sum[7:0];
  endfunction

  function automatic logic [7:0] pos_dec(input logic [7:0] pos, input int unsigned step);
    logic [8:0] wide;
    wide = {1'b0, pos};
    return (wide < 9'(step)) ? 8'd0 : 8'(wide - 9'(step));
  endfunction

endpackage

// File: rtl/lcd_sprite_ctrl_if.sv
// Key/vsync inputs and sprite position outputs between the board, the controller
// and the RGB pattern generator.
interface lcd_sprite_ctrl_if;
  logic [3:0] i_key_n;
  logic       i_lcd_vs;
  logic [7:0] o_reg_A;
  logic [7:0] o_reg_B;
  logic       o_sel;
  logic       o_auto;

  modport master (
    output i_key_n,
    output i_lcd_vs,
    input  o_reg_A,
    input  o_reg_B,
    input  o_sel,
    input  o_auto
  );

  modport slave (
    input  i_key_n,
    input  i_lcd_vs,
    output o_reg_A,
    output o_reg_B,
    output o_sel,
    output o_auto
  );
endinterface

// File: rtl/key_debounce.sv
// One active-low key: 2-flop synchroniser, stability counter, press pulse.
// The counter only runs while the synchronised level differs from the accepted one.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 660000
) (
  input  logic i_rgb_clk,
  input  logic i_rgb_rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          acc_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_rgb_clk or posedge i_rgb_rst) begin
    if (i_rgb_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      o_press <= 1'b0;
    end else begin
      sync1_q <= i_key_n;
      sync2_q <= sync1_q;
      o_press <= 1'b0;
      // Level back at the accepted value means the candidate change was a glitch.
      if (sync2_q == acc_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        acc_q   <= sync2_q;
        cnt_q   <= '0;
        o_press <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_sprite_ctrl.sv
// Key-driven sprite X-offset controller; position changes commit only on the vsync edge
// so a frame never shows a half-moved sprite.
module lcd_sprite_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 660000,
  parameter int unsigned STEP         = 4,
  parameter int unsigned MAX_POS      = 255,
  parameter int unsigned INIT_A       = 0,
  parameter int unsigned INIT_B       = 0,
  parameter logic        VS_ACTIVE    = 1'b1
) (
  input  logic               i_rgb_clk,
  input  logic               i_rgb_rst,
  lcd_sprite_ctrl_if.slave   bus
);

  logic [3:0] press;
  state_e     state_q;
  cmd_e       pend_q;
  logic [7:0] reg_a_q;
  logic [7:0] reg_b_q;
  logic       sel_q;
  logic       auto_q;
  logic       vs_q;
  logic       commit;
  logic [7:0] cur_pos;
  logic [7:0] new_pos;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key_debounce (
      .i_rgb_clk(i_rgb_clk),
      .i_rgb_rst(i_rgb_rst),
      .i_key_n  (bus.i_key_n[k]),
      .o_press  (press[k])
    );
  end

  assign commit = (bus.i_lcd_vs == VS_ACTIVE) && (vs_q != VS_ACTIVE);

  always_comb begin
    cur_pos = sel_q ? reg_b_q : reg_a_q;
    new_pos = cur_pos;
    unique case (state_q)
      StManual: begin
        if (pend_q == CmdInc) new_pos = pos_inc(cur_pos, STEP, MAX_POS);
        else if (pend_q == CmdDec) new_pos = pos_dec(cur_pos, STEP);
      end
      StSweepUp:   new_pos = pos_inc(cur_pos, STEP, MAX_POS);
      StSweepDown: new_pos = pos_dec(cur_pos, STEP);
      default:     new_pos = cur_pos;
    endcase
  end

  // Later assignments intentionally win: a new press beats the commit's pending clear,
  // and the auto toggle beats a sweep direction change in the same cycle.
  always_ff @(posedge i_rgb_clk or posedge i_rgb_rst) begin
    if (i_rgb_rst) begin
      state_q <= StManual;
      pend_q  <= CmdNone;
      reg_a_q <= 8'(INIT_A);
      reg_b_q <= 8'(INIT_B);
      sel_q   <= 1'b0;
      auto_q  <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      vs_q <= bus.i_lcd_vs;
      if (commit) begin
        if (sel_q) reg_b_q <= new_pos;
        else       reg_a_q <= new_pos;
        pend_q <= CmdNone;
        if (state_q == StSweepUp && new_pos == 8'(MAX_POS)) state_q <= StSweepDown;
        if (state_q == StSweepDown && new_pos == 8'd0)      state_q <= StSweepUp;
      end
      if (!auto_q && press[KEY_RIGHT])     pend_q <= CmdInc;
      else if (!auto_q && press[KEY_LEFT]) pend_q <= CmdDec;
      if (press[KEY_SEL]) sel_q <= ~sel_q;
      if (press[KEY_AUTO]) begin
        auto_q  <= ~auto_q;
        state_q <= auto_q ? StManual : StSweepUp;
        if (!auto_q) pend_q <= CmdNone;
      end
    end
  end

  assign bus.o_reg_A = reg_a_q;
  assign bus.o_reg_B = reg_b_q;
  assign bus.o_sel   = sel_q;
  assign bus.o_auto  = auto_q;

endmodule

// File: tb/tb_lcd_sprite_ctrl.sv
// Directed bench for lcd_sprite_ctrl with DEBOUNCE_CYC=4, STEP=4, MAX_POS=20.
// A second instance (INIT_A=INIT_B=2) is held in reset until the final step.
module tb_lcd_sprite_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst2 = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  lcd_sprite_ctrl_if bus ();
  lcd_sprite_ctrl_if bus2 ();

  assign bus2.i_key_n  = bus.i_key_n;
  assign bus2.i_lcd_vs = bus.i_lcd_vs;

  lcd_sprite_ctrl #(
    .DEBOUNCE_CYC(4), .STEP(4), .MAX_POS(20), .INIT_A(0), .INIT_B(0), .VS_ACTIVE(1'b1)
  ) dut (
    .i_rgb_clk(clk),
    .i_rgb_rst(rst),
    .bus      (bus.slave)
  );

  lcd_sprite_ctrl #(
    .DEBOUNCE_CYC(4), .STEP(4), .MAX_POS(20), .INIT_A(2), .INIT_B(2), .VS_ACTIVE(1'b1)
  ) dut2 (
    .i_rgb_clk(clk),
    .i_rgb_rst(rst2),
    .bus      (bus2.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_key(input int idx);
    @(negedge clk) bus.i_key_n[idx] = 1'b0;
    repeat (10) @(negedge clk);
    bus.i_key_n[idx] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic vs_pulse();
    @(negedge clk) bus.i_lcd_vs = 1'b1;
    @(negedge clk) bus.i_lcd_vs = 1'b0;
  endtask

  initial begin
    logic [7:0] sweep_exp [12];
    logic [7:0] sat_exp [7];
    sweep_exp = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'd16, 8'd12, 8'd8, 8'd4, 8'd0, 8'd4, 8'd8};
    sat_exp   = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'd20, 8'd20};
    bus.i_key_n  = 4'hF;
    bus.i_lcd_vs = 1'b0;

    // Asynchronous reset, asserted between clock edges.
    #3 rst = 1'b1;
    rst2 = 1'b1;
    #1;
    chk("rst_reg_A", bus.o_reg_A, 8'd0);
    chk("rst_reg_B", bus.o_reg_B, 8'd0);
    chk("rst_sel", {7'd0, bus.o_sel}, 8'd0);
    chk("rst_auto", {7'd0, bus.o_auto}, 8'd0);
    chk("rst2_reg_A", bus2.o_reg_A, 8'd2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Manual right press commits only at vsync.
    press_key(2);
    chk("pre_vs_reg_A", bus.o_reg_A, 8'd0);
    vs_pulse();
    chk("right_reg_A", bus.o_reg_A, 8'd4);
    chk("right_reg_B", bus.o_reg_B, 8'd0);
    press_key(2);
    vs_pulse();
    chk("right2_reg_A", bus.o_reg_A, 8'd8);

    // Two lefts in one frame apply a single DEC.
    press_key(1);
    press_key(1);
    vs_pulse();
    chk("dbl_left_reg_A", bus.o_reg_A, 8'd4);

    // 3-cycle glitch is filtered.
    @(negedge clk) bus.i_key_n[2] = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_key_n[2] = 1'b1;
    repeat (10) @(negedge clk);
    vs_pulse();
    chk("glitch_reg_A", bus.o_reg_A, 8'd4);

    // Select B, saturate at MAX_POS.
    press_key(0);
    chk("sel_B", {7'd0, bus.o_sel}, 8'd1);
    for (int i = 0; i < 7; i++) begin
      press_key(2);
      vs_pulse();
      chk($sformatf("sat_reg_B_%0d", i), bus.o_reg_B, sat_exp[i]);
    end
    chk("sat_reg_A", bus.o_reg_A, 8'd4);

    // Back to A, bring it to 0.
    press_key(0);
    chk("sel_A", {7'd0, bus.o_sel}, 8'd0);
    press_key(1);
    vs_pulse();
    chk("left_reg_A", bus.o_reg_A, 8'd0);

    // Auto sweep with reversal at both limits; manual keys ignored.
    press_key(3);
    chk("auto_on", {7'd0, bus.o_auto}, 8'd1);
    for (int i = 0; i < 12; i++) begin
      vs_pulse();
      chk($sformatf("sweep_%0d", i), bus.o_reg_A, sweep_exp[i]);
      if (i == 2) press_key(2);
    end
    press_key(1);
    press_key(3);
    chk("auto_off", {7'd0, bus.o_auto}, 8'd0);
    vs_pulse();
    chk("post_auto_reg_A", bus.o_reg_A, 8'd8);

    // Right press pulse lands on the same edge as the vsync commit.
    @(negedge clk) bus.i_key_n[2] = 1'b0;
    repeat (6) @(negedge clk);
    bus.i_lcd_vs = 1'b1;
    @(negedge clk) bus.i_lcd_vs = 1'b0;
    chk("same_cyc_reg_A", bus.o_reg_A, 8'd8);
    repeat (4) @(negedge clk);
    bus.i_key_n[2] = 1'b1;
    repeat (10) @(negedge clk);
    vs_pulse();
    chk("next_frame_reg_A", bus.o_reg_A, 8'd12);

    // Mid-operation reset, with a debounce partly counted.
    @(negedge clk) bus.i_key_n[2] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_reg_A", bus.o_reg_A, 8'd0);
    chk("mid_rst_reg_B", bus.o_reg_B, 8'd0);
    chk("mid_rst_sel", {7'd0, bus.o_sel}, 8'd0);
    @(negedge clk) bus.i_key_n[2] = 1'b1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    vs_pulse();
    chk("post_rst_reg_A", bus.o_reg_A, 8'd0);

    // DEC below STEP clamps to 0 (second instance, B starts at 2).
    rst2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_reg_B", bus2.o_reg_B, 8'd2);
    press_key(0);
    chk("sel2_B", {7'd0, bus2.o_sel}, 8'd1);
    press_key(1);
    vs_pulse();
    chk("clamp_reg_B", bus2.o_reg_B, 8'd0);
    chk("clamp_reg_A", bus2.o_reg_A, 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
